// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions used by both the transmit generator and this
// receive-side checker. Polynomial x^9 + x^5 + 1: new LSB = s[8] ^ s[4].
package prbs_pkg;

  localparam int PRBS_LEN     = 9;
  localparam int TAP_HI       = 8;
  localparam int TAP_LO       = 4;
  localparam int PRBS9_PERIOD = 511;

  // Checker state; exported so benches and checkers can decode r_state.
  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Next PRBS9 bit predicted from a history register with bit 0 newest.
  function automatic logic prbs9_predict(input logic [PRBS_LEN-1:0] h);
    return h[TAP_HI] ^ h[TAP_LO];
  endfunction

endpackage

// File: rtl/prbs9_checker_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
  parameter int NB = 32
) (
  input  logic          clock,
  input  logic          i_reset,
  input  logic          i_clear,
  input  logic          i_inc,
  output logic [NB-1:0] o_count
);

  logic [NB-1:0] r_count;

  // Count up on i_inc, stick at all-ones, clear on i_clear.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {NB{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/prbs9_checker.sv
// Receive-side PRBS9 checker: self-synchronises to the incoming stream,
// declares lock, counts checked bits and bit errors, drops lock when too
// many errors land in one window.
//
// Input qualification: there is no ready/backpressure. A bit is consumed
// exactly on cycles where w_valid = i_enb_rx & i_enable is high; on every
// other cycle all state holds and only o_error falls back to 0.
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int NB_CNT   = 32,
  parameter int LOCK_LEN = 16,
  parameter int ERR_WIN  = 64,
  parameter int ERR_MAX  = 8
) (
  input  logic              clock,
  input  logic              i_reset,
  input  logic              i_enb_rx,
  input  logic              i_enable,
  input  logic              i_bit,
  input  logic              i_clear,
  output logic              o_lock,
  output logic              o_error,
  output logic [NB_CNT-1:0] o_bit_count,
  output logic [NB_CNT-1:0] o_err_count
);

  localparam int NB_FILL  = $clog2(PRBS_LEN + 1);
  localparam int NB_MATCH = $clog2(LOCK_LEN + 1);
  localparam int NB_WIN   = $clog2(ERR_WIN);
  localparam int NB_WERR  = $clog2(ERR_MAX + 1);

  // Registered state (r_state is the FSM state visible to checkers).
  state_t                r_state;
  logic [PRBS_LEN-1:0]   r_hist;
  logic [NB_FILL-1:0]    r_fill;
  logic [NB_MATCH-1:0]   r_match;
  logic [NB_WIN-1:0]     r_win_cnt;
  logic [NB_WERR-1:0]    r_win_err;
  logic                  r_error;

  // Next-state values.
  state_t                w_state_next;
  logic [PRBS_LEN-1:0]   w_hist_next;
  logic [NB_FILL-1:0]    w_fill_next;
  logic [NB_MATCH-1:0]   w_match_next;
  logic [NB_WIN-1:0]     w_win_cnt_next;
  logic [NB_WERR-1:0]    w_win_err_next;
  logic                  w_error_next;

  logic                  w_valid;
  logic                  w_pred;
  logic                  w_locked;
  logic                  w_err_now;
  logic                  w_cnt_inc;
  logic [NB_WERR-1:0]    w_werr_sum;
  logic [NB_MATCH-1:0]   w_match_inc;

  assign w_valid     = i_enb_rx & i_enable;
  assign w_pred      = prbs9_predict(r_hist);
  assign w_locked    = (r_state == ST_LOCKED);
  assign w_cnt_inc   = w_valid & w_locked;
  assign w_err_now   = w_cnt_inc & (i_bit != w_pred);
  assign w_werr_sum  = r_win_err + {{(NB_WERR-1){1'b0}}, w_err_now};
  assign w_match_inc = r_match + 1'b1;

  // State registers; asynchronous active-low reset clears everything.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= ST_SEARCH;
      r_hist    <= '0;
      r_fill    <= '0;
      r_match   <= '0;
      r_win_cnt <= '0;
      r_win_err <= '0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_hist    <= w_hist_next;
      r_fill    <= w_fill_next;
      r_match   <= w_match_next;
      r_win_cnt <= w_win_cnt_next;
      r_win_err <= w_win_err_next;
      r_error   <= w_error_next;
    end
  end

  // Search/lock decisions, history update and loss-of-lock window.
  always_comb begin
    w_state_next   = r_state;
    w_hist_next    = r_hist;
    w_fill_next    = r_fill;
    w_match_next   = r_match;
    w_win_cnt_next = r_win_cnt;
    w_win_err_next = r_win_err;
    w_error_next   = 1'b0;

    if (w_valid) begin
      case (r_state)
        ST_SEARCH: begin
          // Received bits feed the history so it aligns to the stream.
          w_hist_next = {r_hist[PRBS_LEN-2:0], i_bit};
          if (r_fill != NB_FILL'(PRBS_LEN)) begin
            w_fill_next = r_fill + 1'b1;
          end else if ((i_bit == w_pred) && (r_hist != '0)) begin
            // An all-zero history never accumulates matches.
            if (w_match_inc == NB_MATCH'(LOCK_LEN)) begin
              w_state_next   = ST_LOCKED;
              w_match_next   = '0;
              w_win_cnt_next = '0;
              w_win_err_next = '0;
            end else begin
              w_match_next = w_match_inc;
            end
          end else begin
            w_match_next = '0;
          end
        end

        ST_LOCKED: begin
          // Local LFSR free-runs so one flipped bit costs one error only.
          w_hist_next  = {r_hist[PRBS_LEN-2:0], w_pred};
          w_error_next = w_err_now;
          if (w_werr_sum >= NB_WERR'(ERR_MAX)) begin
            w_state_next   = ST_SEARCH;
            w_fill_next    = '0;
            w_match_next   = '0;
            w_win_cnt_next = '0;
            w_win_err_next = '0;
          end else if (r_win_cnt == NB_WIN'(ERR_WIN - 1)) begin
            w_win_cnt_next = '0;
            w_win_err_next = '0;
          end else begin
            w_win_cnt_next = r_win_cnt + 1'b1;
            w_win_err_next = w_werr_sum;
          end
        end

        default: begin
          w_state_next = ST_SEARCH;
        end
      endcase
    end
  end

  sat_counter #(.NB(NB_CNT)) u_bit_cnt (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_inc   (w_cnt_inc),
    .o_count (o_bit_count)
  );

  sat_counter #(.NB(NB_CNT)) u_err_cnt (
    .clock   (clock),
    .i_reset (i_reset),
    .i_clear (i_clear),
    .i_inc   (w_err_now),
    .o_count (o_err_count)
  );

  assign o_lock  = w_locked;
  assign o_error = r_error;

endmodule

// File: tb/tb_prbs9_checker.sv
// Directed bench for prbs9_checker: a PRBS9 generator model (seed 9'h1AA)
// drives the checker; expected values are hand-derived constants.
module tb_prbs9_checker;
  import prbs_pkg::*;

  localparam int NB_CNT = 32;

  logic              clock;
  logic              i_reset;
  logic              i_enb_rx;
  logic              i_enable;
  logic              i_bit;
  logic              i_clear;
  logic              o_lock;
  logic              o_error;
  logic [NB_CNT-1:0] o_bit_count;
  logic [NB_CNT-1:0] o_err_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [PRBS_LEN-1:0] gen;
  logic                seen_lock;
  logic                seen_err;

  prbs9_checker #(
    .NB_CNT   (NB_CNT),
    .LOCK_LEN (16),
    .ERR_WIN  (64),
    .ERR_MAX  (8)
  ) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enb_rx    (i_enb_rx),
    .i_enable    (i_enable),
    .i_bit       (i_bit),
    .i_clear     (i_clear),
    .o_lock      (o_lock),
    .o_error     (o_error),
    .o_bit_count (o_bit_count),
    .o_err_count (o_err_count)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic send(input logic b, input logic en, input logic enb, input logic clr);
    i_bit    = b;
    i_enable = en;
    i_enb_rx = enb;
    i_clear  = clr;
    @(posedge clock);
    #1;
    if (o_lock)  seen_lock = 1'b1;
    if (o_error) seen_err  = 1'b1;
  endtask

  // Transmit generator model: MSB-first, new LSB = s[8]^s[4].
  task automatic next_gen(output logic b);
    b   = gen[TAP_HI];
    gen = {gen[PRBS_LEN-2:0], gen[TAP_HI] ^ gen[TAP_LO]};
  endtask

  task automatic send_gen(input logic flip);
    logic b;
    next_gen(b);
    send(b ^ flip, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    i_reset  = 1'b0;
    i_enb_rx = 1'b0;
    i_enable = 1'b0;
    i_bit    = 1'b0;
    i_clear  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    i_reset   = 1'b1;
    gen       = 9'h1AA;
    seen_lock = 1'b0;
    seen_err  = 1'b0;
  endtask

  initial begin
    logic b;

    // Reset state.
    do_reset();
    check("rst_lock",  32'(o_lock),  0);
    check("rst_error", 32'(o_error), 0);
    check("rst_bits",  o_bit_count,  0);
    check("rst_errs",  o_err_count,  0);

    // Test 1: lock after 25 bits, then one full period clean.
    repeat (24) send_gen(1'b0);
    check("t1_lock_at_24", 32'(o_lock), 0);
    send_gen(1'b0);
    check("t1_lock_at_25", 32'(o_lock), 1);
    check("t1_bits_at_lock", o_bit_count, 0);
    repeat (PRBS9_PERIOD) send_gen(1'b0);
    check("t1_bits_511", o_bit_count, 511);
    check("t1_errs_0",   o_err_count, 0);
    check("t1_no_error_pulse", 32'(seen_err), 0);

    // Test 2: single flipped bit.
    send_gen(1'b1);
    check("t2_error_pulse", 32'(o_error), 1);
    check("t2_errs_1",      o_err_count,  1);
    check("t2_lock_held",   32'(o_lock),  1);
    send_gen(1'b0);
    check("t2_error_drop",  32'(o_error), 0);
    check("t2_bits_513",    o_bit_count,  513);

    // Clear on a clean valid bit: zero, bit not counted.
    next_gen(b);
    send(b, 1'b1, 1'b1, 1'b1);
    check("clr_bits", o_bit_count, 0);
    check("clr_errs", o_err_count, 0);
    check("clr_lock", 32'(o_lock), 1);

    // Test 3: 8 errors within one window (every 4th bit).
    for (int i = 0; i < 29; i++) begin
      send_gen((i % 4) == 0);
      if (i == 27) check("t3_lock_before_8th", 32'(o_lock), 1);
    end
    check("t3_lock_lost", 32'(o_lock), 0);
    check("t3_errs_8",    o_err_count, 8);
    check("t3_bits_29",   o_bit_count, 29);
    repeat (24) send_gen(1'b0);
    check("t3_relock_24", 32'(o_lock), 0);
    send_gen(1'b0);
    check("t3_relock_25", 32'(o_lock), 1);
    check("t3_bits_frozen_in_search", o_bit_count, 29);
    check("t3_errs_frozen_in_search", o_err_count, 8);

    // Test 4: constant zeros and constant ones never lock.
    do_reset();
    repeat (1000) send(1'b0, 1'b1, 1'b1, 1'b0);
    check("t4_zero_lock", 32'(seen_lock), 0);
    check("t4_zero_bits", o_bit_count, 0);
    check("t4_zero_errs", o_err_count, 0);
    do_reset();
    repeat (1000) send(1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_ones_lock", 32'(seen_lock), 0);
    check("t4_ones_bits", o_bit_count, 0);

    // Test 5: sparse enable and receive freeze while locked.
    do_reset();
    repeat (25) send_gen(1'b0);
    check("t5_locked", 32'(o_lock), 1);
    seen_err = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if ((i % 3) == 2) send_gen(1'b0);
      else send(1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    end
    check("t5_bits_sparse", o_bit_count, 10);
    repeat (50) send(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
    check("t5_bits_frozen", o_bit_count, 10);
    check("t5_lock_frozen", 32'(o_lock), 1);
    repeat (10) send_gen(1'b0);
    check("t5_bits_20",  o_bit_count, 20);
    check("t5_errs_0",   o_err_count, 0);
    check("t5_no_error", 32'(seen_err), 0);
    check("t5_lock",     32'(o_lock), 1);

    // Test 6: clear coincident with an errored bit, then async reset.
    next_gen(b);
    send(~b, 1'b1, 1'b1, 1'b1);
    check("t6_clr_bits",  o_bit_count,  0);
    check("t6_clr_errs",  o_err_count,  0);
    check("t6_clr_lock",  32'(o_lock),  1);
    check("t6_clr_error", 32'(o_error), 1);
    send_gen(1'b1);
    check("t6_errs_1", o_err_count, 1);
    check("t6_bits_1", o_bit_count, 1);
    #2;
    i_reset = 1'b0;
    #1;
    check("t6_rst_lock",  32'(o_lock),  0);
    check("t6_rst_error", 32'(o_error), 0);
    check("t6_rst_bits",  o_bit_count,  0);
    check("t6_rst_errs",  o_err_count,  0);
    @(posedge clock);
    #1;
    i_reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
